// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: sequencer for a 4x4 memory-card board.
// It owns the selection cursor, the face-up and matched card masks, the
// two-card compare with timed hide-back, the pair and attempt counters,
// and the win condition.
// Optional build macro ATTEMPT_LIMIT_EN enables a LOSE state. It is entered
// on a mismatch once attempts reaches MAX_ATTEMPTS, and it reveals the
// whole board.
module memory_game_ctrl #(
   parameter int SHOW_CYCLES  = 25000000,
   parameter int MAX_ATTEMPTS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_sel,
   input  logic [47:0] board_ids,
   output logic [3:0]  cursor,
   output logic [15:0] face_up,
   output logic [15:0] matched,
   output logic [3:0]  pairs_found,
   output logic [7:0]  attempts,
   output logic [2:0]  state,
   output logic        win,
   output logic        lose
);

   localparam int TW = $clog2(SHOW_CYCLES + 1);
   localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);

   typedef enum logic [2:0] {
      PICK1 = 3'd0,
      PICK2 = 3'd1,
      CHECK = 3'd2,
      SHOW  = 3'd3,
      WIN   = 3'd4,
      LOSE  = 3'd5
   } state_t;

   state_t        st;
   logic [TW-1:0] timer;
   logic [3:0]    first;
   logic [3:0]    second;
   logic [1:0]    row;
   logic [1:0]    col;
   logic [3:0]    cursor_nxt;
   logic          ids_equal;

   // Pair ID of card p, packed 3 bits per position.
   function automatic logic [2:0] card_id(input logic [47:0] ids, input logic [3:0] p);
      card_id = ids[3*p +: 3];
   endfunction

   assign state     = st;
   assign ids_equal = (card_id(board_ids, first) == card_id(board_ids, second));

   // Next cursor position from the direction buttons.
   // Row and column are 2-bit fields, so they wrap on their own.
   always_comb begin
      row = cursor[3:2];
      col = cursor[1:0];
      if (btn_up)
         row = row - 2'd1;
      else if (btn_down)
         row = row + 2'd1;
      else if (btn_left)
         col = col - 2'd1;
      else if (btn_right)
         col = col + 2'd1;
      cursor_nxt = {row, col};
   end

`ifdef ATTEMPT_LIMIT_EN
   localparam logic [8:0] MAX_A = 9'(MAX_ATTEMPTS);
`else
   assign lose = 1'b0;
`endif

   // Game FSM with all outputs registered. start restarts the game from
   // any state and takes priority over the buttons.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= PICK1;
         cursor      <= 4'd0;
         face_up     <= 16'd0;
         matched     <= 16'd0;
         pairs_found <= 4'd0;
         attempts    <= 8'd0;
         win         <= 1'b0;
         timer       <= '0;
         first       <= 4'd0;
         second      <= 4'd0;
`ifdef ATTEMPT_LIMIT_EN
         lose        <= 1'b0;
`endif
      end else if (start) begin
         st          <= PICK1;
         cursor      <= 4'd0;
         face_up     <= 16'd0;
         matched     <= 16'd0;
         pairs_found <= 4'd0;
         attempts    <= 8'd0;
         win         <= 1'b0;
         timer       <= '0;
         first       <= 4'd0;
         second      <= 4'd0;
`ifdef ATTEMPT_LIMIT_EN
         lose        <= 1'b0;
`endif
      end else begin
         case (st)
            PICK1: begin
               if (btn_sel) begin
                  if (!face_up[cursor]) begin
                     face_up[cursor] <= 1'b1;
                     first           <= cursor;
                     st              <= PICK2;
                  end
               end else begin
                  cursor <= cursor_nxt;
               end
            end
            PICK2: begin
               if (btn_sel) begin
                  if (!face_up[cursor]) begin
                     face_up[cursor] <= 1'b1;
                     second          <= cursor;
                     if (attempts != 8'hFF)
                        attempts <= attempts + 8'd1;
                     st <= CHECK;
                  end
               end else begin
                  cursor <= cursor_nxt;
               end
            end
            CHECK: begin
               if (ids_equal) begin
                  matched[first]  <= 1'b1;
                  matched[second] <= 1'b1;
                  pairs_found     <= pairs_found + 4'd1;
                  if (pairs_found == 4'd7) begin
                     win <= 1'b1;
                     st  <= WIN;
                  end else begin
                     st <= PICK1;
                  end
               end else begin
`ifdef ATTEMPT_LIMIT_EN
                  if ({1'b0, attempts} >= MAX_A) begin
                     lose    <= 1'b1;
                     face_up <= 16'hFFFF;
                     st      <= LOSE;
                  end else begin
                     timer <= SHOW_LOAD;
                     st    <= SHOW;
                  end
`else
                  timer <= SHOW_LOAD;
                  st    <= SHOW;
`endif
               end
            end
            SHOW: begin
               if (timer == '0) begin
                  face_up[first]  <= 1'b0;
                  face_up[second] <= 1'b0;
                  st              <= PICK1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            WIN, LOSE: begin
               st <= st;
            end
            default: begin
               st <= PICK1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed testbench for memory_game_ctrl. SHOW_CYCLES=4, and card p holds
// pair ID p>>1. When ATTEMPT_LIMIT_EN is defined, the limit is 3 attempts.
module tb_memory_game_ctrl;

   localparam int SHOW_N = 4;
   localparam int MAX_A  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
   logic [47:0] board_ids;
   logic [3:0]  cursor;
   logic [15:0] face_up;
   logic [15:0] matched;
   logic [3:0]  pairs_found;
   logic [7:0]  attempts;
   logic [2:0]  state;
   logic        win;
   logic        lose;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] cur;

   memory_game_ctrl #(.SHOW_CYCLES(SHOW_N), .MAX_ATTEMPTS(MAX_A)) dut (
      .clk(clk), .reset(reset), .start(start),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_sel(btn_sel), .board_ids(board_ids),
      .cursor(cursor), .face_up(face_up), .matched(matched),
      .pairs_found(pairs_found), .attempts(attempts), .state(state),
      .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // 0 sel, 1 up, 2 down, 3 left, 4 right, 5 start
   task automatic pulse(input int b);
      @(negedge clk);
      case (b)
         0: btn_sel   = 1'b1;
         1: btn_up    = 1'b1;
         2: btn_down  = 1'b1;
         3: btn_left  = 1'b1;
         4: btn_right = 1'b1;
         default: start = 1'b1;
      endcase
      @(negedge clk);
      btn_sel = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      btn_left = 1'b0; btn_right = 1'b0; start = 1'b0;
   endtask

   task automatic move_to(input logic [3:0] t);
      while (cur[3:2] != t[3:2]) begin
         pulse(2);
         cur[3:2] = cur[3:2] + 2'd1;
      end
      while (cur[1:0] != t[1:0]) begin
         pulse(4);
         cur[1:0] = cur[1:0] + 2'd1;
      end
   endtask

   task automatic sel_at(input logic [3:0] t);
      move_to(t);
      pulse(0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
      for (int p = 0; p < 16; p++) board_ids[3*p +: 3] = 3'(p >> 1);
      cur = 4'd0;
      #23;
      check_val("rst_state", 32'(state), 0);
      check_val("rst_cursor", 32'(cursor), 0);
      check_val("rst_face", 32'(face_up), 0);
      check_val("rst_matched", 32'(matched), 0);
      check_val("rst_pairs", 32'(pairs_found), 0);
      check_val("rst_attempts", 32'(attempts), 0);
      check_val("rst_win", 32'(win), 0);
      check_val("rst_lose", 32'(lose), 0);
      @(negedge clk);
      reset = 1'b0;

      // cursor wrap
      pulse(1); check_val("up_wrap", 32'(cursor), 12);
      pulse(3); check_val("left_wrap", 32'(cursor), 15);
      pulse(4); check_val("right_wrap", 32'(cursor), 12);
      cur = 4'd12;

      // first matching pair 0/1
      sel_at(4'd0);
      check_val("p1_state", 32'(state), 1);
      check_val("p1_face", 32'(face_up), 32'h1);
      sel_at(4'd1);
      check_val("chk_state", 32'(state), 2);
      check_val("chk_face", 32'(face_up), 32'h3);
      check_val("chk_attempts", 32'(attempts), 1);
      tick();
      check_val("m1_state", 32'(state), 0);
      check_val("m1_matched", 32'(matched), 32'h3);
      check_val("m1_face", 32'(face_up), 32'h3);
      check_val("m1_pairs", 32'(pairs_found), 1);

      // non-selectable cards are ignored
      sel_at(4'd0);
      check_val("ign_matched_state", 32'(state), 0);
      check_val("ign_matched_face", 32'(face_up), 32'h3);
      sel_at(4'd4);
      check_val("sel4_state", 32'(state), 1);
      check_val("sel4_face", 32'(face_up), 32'h13);
      pulse(0);
      check_val("ign_same_state", 32'(state), 1);
      check_val("ign_same_attempts", 32'(attempts), 1);

      // mismatch 4/6: visible through CHECK plus SHOW_N SHOW cycles
      sel_at(4'd6);
      check_val("mm_chk_state", 32'(state), 2);
      check_val("mm_chk_face", 32'(face_up), 32'h53);
      check_val("mm_attempts", 32'(attempts), 2);
      for (int i = 0; i < SHOW_N; i++) begin
         tick();
         check_val("mm_show_state", 32'(state), 3);
         check_val("mm_show_face", 32'(face_up), 32'h53);
      end
      tick();
      check_val("mm_end_state", 32'(state), 0);
      check_val("mm_end_face", 32'(face_up), 32'h3);

      // remaining seven pairs -> WIN
      for (int k = 1; k < 8; k++) begin
         sel_at(4'(2 * k));
         sel_at(4'(2 * k + 1));
         tick();
         check_val("pairs_cnt", 32'(pairs_found), 32'(k + 1));
      end
      check_val("win_state", 32'(state), 4);
      check_val("win_flag", 32'(win), 1);
      check_val("win_matched", 32'(matched), 32'hFFFF);
      check_val("win_attempts", 32'(attempts), 9);
      pulse(1);
      check_val("win_btn_cursor", 32'(cursor), 32'(cur));
      pulse(0);
      check_val("win_btn_state", 32'(state), 4);

      // start beats a simultaneous button
      @(negedge clk);
      start = 1'b1; btn_up = 1'b1;
      @(negedge clk);
      start = 1'b0; btn_up = 1'b0;
      cur = 4'd0;
      check_val("start_state", 32'(state), 0);
      check_val("start_cursor", 32'(cursor), 0);
      check_val("start_pairs", 32'(pairs_found), 0);
      check_val("start_attempts", 32'(attempts), 0);
      check_val("start_matched", 32'(matched), 0);
      check_val("start_face", 32'(face_up), 0);
      check_val("start_win", 32'(win), 0);

      // two full mismatches, then the attempt that hits the limit
      for (int j = 0; j < MAX_A - 1; j++) begin
         sel_at(4'd0);
         sel_at(4'd2);
         for (int i = 0; i <= SHOW_N; i++) tick();
         check_val("rep_mm_state", 32'(state), 0);
         check_val("rep_mm_face", 32'(face_up), 0);
      end
      check_val("rep_mm_attempts", 32'(attempts), 32'(MAX_A - 1));
      sel_at(4'd0);
      sel_at(4'd2);
      tick();
`ifdef ATTEMPT_LIMIT_EN
      check_val("lose_state", 32'(state), 5);
      check_val("lose_flag", 32'(lose), 1);
      check_val("lose_face", 32'(face_up), 32'hFFFF);
      pulse(1);
      check_val("lose_btn_cursor", 32'(cursor), 32'(cur));
`else
      check_val("nolimit_state", 32'(state), 3);
      check_val("nolimit_lose", 32'(lose), 0);
`endif
      pulse(5);
      cur = 4'd0;
      check_val("restart_state", 32'(state), 0);
      check_val("restart_lose", 32'(lose), 0);
      check_val("restart_face", 32'(face_up), 0);

      // asynchronous reset in the middle of SHOW
      sel_at(4'd0);
      sel_at(4'd2);
      tick();
      tick();
      check_val("pre_rst_state", 32'(state), 3);
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_state", 32'(state), 0);
      check_val("arst_cursor", 32'(cursor), 0);
      check_val("arst_face", 32'(face_up), 0);
      check_val("arst_attempts", 32'(attempts), 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check_val("post_rst_state", 32'(state), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
